// File: rtl/trap_ctrl.sv
// trap_ctrl: retire-stage trap/return sequencer.
// Picks the highest-priority synchronous exception, enabled M-mode interrupt
// or mret on a valid retiring instruction. It then computes the new
// mcause/mepc/mtval/mstatus, strobes the CSR exception-write port, and
// redirects fetch to the trap vector or to mepc.
// Ports:
//   clk_i, rst_i (async, active-low)
//   retire inputs : valid_i, pc_i, instr_i, exc_*_i, addr_i, mret_i
//   interrupts    : meip_i, mtip_i, mie_meie_i, mie_mtie_i
//   CSR state     : mstatus_q_i, mcause_q_i, mepc_q_i, mtval_q_i, target_i
//   CSR write     : we_exc_o, mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, aux_o
//   pipeline      : stall_o (combinational), flush_o, redirect_o, redirect_pc_o
module trap_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter bit          VECTORED = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            exc_fetch_mis_i,
    input  logic            exc_illegal_i,
    input  logic            exc_ebreak_i,
    input  logic            exc_ecall_i,
    input  logic            exc_load_mis_i,
    input  logic            exc_store_mis_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic            mret_i,
    input  logic            meip_i,
    input  logic            mtip_i,
    input  logic            mie_meie_i,
    input  logic            mie_mtie_i,
    input  logic [XLEN-1:0] mstatus_q_i,
    input  logic [XLEN-1:0] mcause_q_i,
    input  logic [XLEN-1:0] mepc_q_i,
    input  logic [XLEN-1:0] mtval_q_i,
    input  logic [XLEN-1:0] target_i,
    output logic            we_exc_o,
    output logic [XLEN-1:0] mcause_d_o,
    output logic [XLEN-1:0] mepc_d_o,
    output logic [XLEN-1:0] mtval_d_o,
    output logic [XLEN-1:0] mstatus_d_o,
    output logic            aux_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam logic [XLEN-1:0] CAUSE_MEI       = XLEN'(32'h8000_000B);
    localparam logic [XLEN-1:0] CAUSE_MTI       = XLEN'(32'h8000_0007);
    localparam logic [XLEN-1:0] CAUSE_FETCH_MIS = XLEN'(32'd0);
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL   = XLEN'(32'd2);
    localparam logic [XLEN-1:0] CAUSE_EBREAK    = XLEN'(32'd3);
    localparam logic [XLEN-1:0] CAUSE_LOAD_MIS  = XLEN'(32'd4);
    localparam logic [XLEN-1:0] CAUSE_STORE_MIS = XLEN'(32'd6);
    localparam logic [XLEN-1:0] CAUSE_ECALL     = XLEN'(32'd11);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic            is_mret_q;
    logic            is_int_q;

    logic            int_mei_c;
    logic            int_mti_c;
    logic            exc_any_c;
    logic            event_c;
    logic            accept_c;
    logic [XLEN-1:0] evt_cause_c;
    logic [XLEN-1:0] evt_tval_c;
    logic [XLEN-1:0] evt_epc_c;
    logic [XLEN-1:0] evt_mstatus_c;
    logic            evt_int_c;
    logic            evt_mret_c;
    logic [XLEN-1:0] trap_mstatus_c;
    logic [XLEN-1:0] mret_mstatus_c;
    logic [XLEN-1:0] redirect_pc_c;

    logic            we_exc_d;
    logic            flush_d;
    logic            redirect_d;
    logic            aux_d;

    // Interrupts count only when globally enabled by mstatus.MIE.
    assign int_mei_c = mstatus_q_i[3] & meip_i & mie_meie_i;
    assign int_mti_c = mstatus_q_i[3] & mtip_i & mie_mtie_i;
    assign exc_any_c = exc_fetch_mis_i | exc_illegal_i | exc_ebreak_i |
                       exc_ecall_i | exc_load_mis_i | exc_store_mis_i;
    assign event_c   = valid_i & (int_mei_c | int_mti_c | exc_any_c | mret_i);

    // mstatus images for trap entry and for mret.
    always_comb begin
        trap_mstatus_c        = mstatus_q_i;
        trap_mstatus_c[7]     = mstatus_q_i[3];
        trap_mstatus_c[3]     = 1'b0;
        trap_mstatus_c[12:11] = 2'b11;
        mret_mstatus_c        = mstatus_q_i;
        mret_mstatus_c[3]     = mstatus_q_i[7];
        mret_mstatus_c[7]     = 1'b1;
        mret_mstatus_c[12:11] = 2'b11;
    end

    // Priority encode the retiring event into cause/tval.
    always_comb begin
        evt_cause_c = '0;
        evt_tval_c  = '0;
        evt_int_c   = 1'b0;
        evt_mret_c  = 1'b0;
        if (int_mei_c) begin
            evt_cause_c = CAUSE_MEI;
            evt_int_c   = 1'b1;
        end else if (int_mti_c) begin
            evt_cause_c = CAUSE_MTI;
            evt_int_c   = 1'b1;
        end else if (exc_fetch_mis_i) begin
            evt_cause_c = CAUSE_FETCH_MIS;
            evt_tval_c  = addr_i;
        end else if (exc_illegal_i) begin
            evt_cause_c = CAUSE_ILLEGAL;
            evt_tval_c  = instr_i;
        end else if (exc_ebreak_i) begin
            evt_cause_c = CAUSE_EBREAK;
            evt_tval_c  = pc_i;
        end else if (exc_ecall_i) begin
            evt_cause_c = CAUSE_ECALL;
        end else if (exc_load_mis_i) begin
            evt_cause_c = CAUSE_LOAD_MIS;
            evt_tval_c  = addr_i;
        end else if (exc_store_mis_i) begin
            evt_cause_c = CAUSE_STORE_MIS;
            evt_tval_c  = addr_i;
        end else if (mret_i) begin
            evt_mret_c  = 1'b1;
        end
    end

    // mret rewrites only mstatus; other CSRs pass through unchanged.
    always_comb begin
        if (evt_mret_c) begin
            evt_cause_c_pass: begin end
            evt_epc_c     = mepc_q_i;
            evt_mstatus_c = mret_mstatus_c;
        end else begin
            evt_epc_c     = {pc_i[XLEN-1:2], 2'b00};
            evt_mstatus_c = trap_mstatus_c;
        end
    end

    // Redirect target, sampled while COMMIT presents mtvec or mepc on target_i.
    always_comb begin
        redirect_pc_c = {target_i[XLEN-1:2], 2'b00};
        if (is_mret_q) begin
            redirect_pc_c = target_i;
        end else if (VECTORED && is_int_q && (target_i[1:0] == 2'b01)) begin
            redirect_pc_c = {target_i[XLEN-1:2], 2'b00} + XLEN'({mcause_d_o[4:0], 2'b00});
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of the registered control outputs.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        we_exc_d   = 1'b0;
        flush_d    = 1'b0;
        redirect_d = 1'b0;
        aux_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (event_c) begin
                    state_d  = ST_COMMIT;
                    accept_c = 1'b1;
                    we_exc_d = 1'b1;
                    flush_d  = 1'b1;
                    aux_d    = evt_mret_c;
                end
            end
            ST_COMMIT: begin
                state_d    = ST_REDIRECT;
                redirect_d = 1'b1;
                flush_d    = 1'b1;
                aux_d      = is_mret_q;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stall rises in the accept cycle itself; reset gates the combinational path.
    assign stall_o = rst_i & (accept_c | (state_q != ST_IDLE));

    // Registered outputs and event latches.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_exc_o      <= 1'b0;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            aux_o         <= 1'b0;
            mcause_d_o    <= '0;
            mepc_d_o      <= '0;
            mtval_d_o     <= '0;
            mstatus_d_o   <= '0;
            redirect_pc_o <= '0;
            is_mret_q     <= 1'b0;
            is_int_q      <= 1'b0;
        end else begin
            we_exc_o   <= we_exc_d;
            flush_o    <= flush_d;
            redirect_o <= redirect_d;
            aux_o      <= aux_d;
            if (accept_c) begin
                mcause_d_o  <= evt_mret_c ? mcause_q_i : evt_cause_c;
                mepc_d_o    <= evt_epc_c;
                mtval_d_o   <= evt_mret_c ? mtval_q_i : evt_tval_c;
                mstatus_d_o <= evt_mstatus_c;
                is_mret_q   <= evt_mret_c;
                is_int_q    <= evt_int_c;
            end
            if (state_q == ST_COMMIT) begin
                redirect_pc_o <= redirect_pc_c;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl. A reference model derives the
// expected CSR write and redirect from the stimulus. The stimulus side queues
// that expectation, and a negedge monitor pops it when the DUT strobes we_exc_o.
module tb_trap_ctrl;

    typedef struct packed {
        logic        valid;
        logic        fetch;
        logic        illegal;
        logic        ebreak;
        logic        ecall;
        logic        load;
        logic        store;
        logic        mret;
        logic        meip;
        logic        mtip;
        logic        meie;
        logic        mtie;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic [31:0] mstatus;
        logic [31:0] mcause_q;
        logic [31:0] mepc_q;
        logic [31:0] mtval_q;
        logic [31:0] mtvec;
    } stim_t;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] mstatus;
        logic        aux;
        logic [31:0] rpc;
    } exp_t;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        exc_fetch_mis_i;
    logic        exc_illegal_i;
    logic        exc_ebreak_i;
    logic        exc_ecall_i;
    logic        exc_load_mis_i;
    logic        exc_store_mis_i;
    logic [31:0] addr_i;
    logic        mret_i;
    logic        meip_i;
    logic        mtip_i;
    logic        mie_meie_i;
    logic        mie_mtie_i;
    logic [31:0] mstatus_q_i;
    logic [31:0] mcause_q_i;
    logic [31:0] mepc_q_i;
    logic [31:0] mtval_q_i;
    logic [31:0] target_i;
    logic [31:0] mtvec;
    logic        we_exc_o;
    logic [31:0] mcause_d_o;
    logic [31:0] mepc_d_o;
    logic [31:0] mtval_d_o;
    logic [31:0] mstatus_d_o;
    logic        aux_o;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // CSR file vector mux: mepc when aux_o selects it, else mtvec.
    assign target_i = aux_o ? mepc_q_i : mtvec;

    trap_ctrl #(.XLEN(32), .VECTORED(1'b1)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .pc_i            (pc_i),
        .instr_i         (instr_i),
        .exc_fetch_mis_i (exc_fetch_mis_i),
        .exc_illegal_i   (exc_illegal_i),
        .exc_ebreak_i    (exc_ebreak_i),
        .exc_ecall_i     (exc_ecall_i),
        .exc_load_mis_i  (exc_load_mis_i),
        .exc_store_mis_i (exc_store_mis_i),
        .addr_i          (addr_i),
        .mret_i          (mret_i),
        .meip_i          (meip_i),
        .mtip_i          (mtip_i),
        .mie_meie_i      (mie_meie_i),
        .mie_mtie_i      (mie_mtie_i),
        .mstatus_q_i     (mstatus_q_i),
        .mcause_q_i      (mcause_q_i),
        .mepc_q_i        (mepc_q_i),
        .mtval_q_i       (mtval_q_i),
        .target_i        (target_i),
        .we_exc_o        (we_exc_o),
        .mcause_d_o      (mcause_d_o),
        .mepc_d_o        (mepc_d_o),
        .mtval_d_o       (mtval_d_o),
        .mstatus_d_o     (mstatus_d_o),
        .aux_o           (aux_o),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: first matching rule in priority order wins.
    function automatic bit model(input stim_t s, output exp_t e);
        logic [31:0] cause [8];
        logic [31:0] tval  [8];
        bit          hit   [8];
        bit          mie;
        e    = '0;
        mie  = s.mstatus[3];
        hit  = '{mie && s.meip && s.meie, mie && s.mtip && s.mtie, s.fetch, s.illegal,
                 s.ebreak, s.ecall, s.load, s.store};
        cause = '{32'h8000_000B, 32'h8000_0007, 32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
        tval  = '{32'd0, 32'd0, s.addr, s.instr, s.pc, 32'd0, s.addr, s.addr};
        if (!s.valid) return 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (hit[i]) begin
                e.cause   = cause[i];
                e.epc     = s.pc & 32'hFFFF_FFFC;
                e.tval    = tval[i];
                e.mstatus = (s.mstatus & ~32'h0000_1888) | 32'h0000_1800 |
                            (s.mstatus[3] ? 32'h80 : 32'h0);
                e.aux     = 1'b0;
                e.rpc     = (s.mtvec & 32'hFFFF_FFFC) +
                            (((i < 2) && (s.mtvec[1:0] == 2'b01)) ? (cause[i] & 32'd31) * 32'd4 : 32'd0);
                return 1'b1;
            end
        end
        if (s.mret) begin
            e.cause   = s.mcause_q;
            e.epc     = s.mepc_q;
            e.tval    = s.mtval_q;
            e.mstatus = (s.mstatus & ~32'h0000_1888) | 32'h0000_1880 |
                        (s.mstatus[7] ? 32'h8 : 32'h0);
            e.aux     = 1'b1;
            e.rpc     = s.mepc_q;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic stim_t base_stim();
        stim_t s;
        s       = '0;
        s.valid = 1'b1;
        s.mtvec = 32'h0000_1000;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        valid_i         = s.valid;
        exc_fetch_mis_i = s.fetch;
        exc_illegal_i   = s.illegal;
        exc_ebreak_i    = s.ebreak;
        exc_ecall_i     = s.ecall;
        exc_load_mis_i  = s.load;
        exc_store_mis_i = s.store;
        mret_i          = s.mret;
        meip_i          = s.meip;
        mtip_i          = s.mtip;
        mie_meie_i      = s.meie;
        mie_mtie_i      = s.mtie;
        pc_i            = s.pc;
        instr_i         = s.instr;
        addr_i          = s.addr;
        mstatus_q_i     = s.mstatus;
        mcause_q_i      = s.mcause_q;
        mepc_q_i        = s.mepc_q;
        mtval_q_i       = s.mtval_q;
        mtvec           = s.mtvec;
    endtask

    task automatic clear_events();
        valid_i         = 1'b0;
        exc_fetch_mis_i = 1'b0;
        exc_illegal_i   = 1'b0;
        exc_ebreak_i    = 1'b0;
        exc_ecall_i     = 1'b0;
        exc_load_mis_i  = 1'b0;
        exc_store_mis_i = 1'b0;
        mret_i          = 1'b0;
        meip_i          = 1'b0;
        mtip_i          = 1'b0;
    endtask

    // Retire-stage events while the sequence is busy; the DUT must ignore them.
    task automatic noise();
        valid_i         = 1'b1;
        exc_fetch_mis_i = 1'($urandom_range(0, 1));
        exc_illegal_i   = 1'($urandom_range(0, 1));
        exc_ebreak_i    = 1'($urandom_range(0, 1));
        exc_ecall_i     = 1'($urandom_range(0, 1));
        exc_load_mis_i  = 1'($urandom_range(0, 1));
        exc_store_mis_i = 1'($urandom_range(0, 1));
        mret_i          = 1'($urandom_range(0, 1));
        meip_i          = 1'($urandom_range(0, 1));
        mtip_i          = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge; returns at the negedge where the next event may be applied.
    task automatic run(input stim_t s, input bit with_noise);
        exp_t e;
        bit   ev;
        ev = model(s, e);
        if (ev) sb.push_back(e);
        apply(s);
        #1;
        chk("stall_accept", 32'(stall_o), 32'(ev));
        @(negedge clk);
        if (ev) begin
            if (with_noise) noise(); else clear_events();
            @(negedge clk);
            if (with_noise) noise();
            @(negedge clk);
        end
        clear_events();
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid    = ($urandom_range(0, 7) != 0);
        s.fetch    = ($urandom_range(0, 7) == 0);
        s.illegal  = ($urandom_range(0, 7) == 0);
        s.ebreak   = ($urandom_range(0, 7) == 0);
        s.ecall    = ($urandom_range(0, 7) == 0);
        s.load     = ($urandom_range(0, 7) == 0);
        s.store    = ($urandom_range(0, 7) == 0);
        s.mret     = ($urandom_range(0, 5) == 0);
        s.meip     = ($urandom_range(0, 3) == 0);
        s.mtip     = ($urandom_range(0, 3) == 0);
        s.meie     = 1'($urandom_range(0, 1));
        s.mtie     = 1'($urandom_range(0, 1));
        s.pc       = $urandom;
        s.instr    = $urandom;
        s.addr     = $urandom;
        s.mstatus  = $urandom;
        s.mcause_q = $urandom;
        s.mepc_q   = $urandom;
        s.mtval_q  = $urandom;
        s.mtvec    = ($urandom & 32'hFFFF_FFFC) |
                     (($urandom_range(0, 1) != 0) ? 32'h1 : 32'($urandom_range(0, 3)));
        return s;
    endfunction

    // Monitor: pops on each CSR write strobe, then checks the redirect one cycle later.
    initial begin
        exp_t cur;
        bit   pend;
        pend = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                chk("redirect_o", 32'(redirect_o), 32'd1);
                chk("redirect_pc", redirect_pc_o, cur.rpc);
                chk("redirect_aux", 32'(aux_o), 32'(cur.aux));
                chk("redirect_stall", 32'(stall_o), 32'd1);
                chk("redirect_flush", 32'(flush_o), 32'd1);
                chk("redirect_we", 32'(we_exc_o), 32'd0);
            end else if (redirect_o) begin
                total++;
                bad++;
                $display("FAIL unexpected_redirect: got redirect_o=1 want 0 at %0t", $time);
            end
            if (we_exc_o) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_we: got we_exc_o=1 want 0 at %0t", $time);
                end else begin
                    cur = sb.pop_front();
                    pend = 1'b1;
                    chk("mcause_d", mcause_d_o, cur.cause);
                    chk("mepc_d", mepc_d_o, cur.epc);
                    chk("mtval_d", mtval_d_o, cur.tval);
                    chk("mstatus_d", mstatus_d_o, cur.mstatus);
                    chk("commit_aux", 32'(aux_o), 32'(cur.aux));
                    chk("commit_stall", 32'(stall_o), 32'd1);
                    chk("commit_flush", 32'(flush_o), 32'd1);
                    chk("commit_redirect", 32'(redirect_o), 32'd0);
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst_i = 1'b0;
        apply('0);
        #12;
        chk("rst_we", 32'(we_exc_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_redirect", 32'(redirect_o), 32'd0);
        chk("rst_aux", 32'(aux_o), 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_mcause", mcause_d_o, 32'd0);
        chk("rst_mstatus", mstatus_d_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);

        // Illegal instruction, direct mtvec.
        s = base_stim(); s.pc = 32'h100; s.instr = 32'hFFFF_FFFF; s.illegal = 1'b1;
        s.mstatus = 32'h8; s.mtvec = 32'h0000_0400;
        run(s, 1'b1);
        // ecall beats load_mis.
        s = base_stim(); s.pc = 32'h40; s.ecall = 1'b1; s.load = 1'b1; s.addr = 32'h123;
        s.mstatus = 32'h8;
        run(s, 1'b0);
        // Vectored external interrupt.
        s = base_stim(); s.pc = 32'h80; s.meip = 1'b1; s.meie = 1'b1; s.mstatus = 32'h8;
        s.mtvec = 32'h201;
        run(s, 1'b1);
        // Exception with vectored mtvec still goes to base.
        s = base_stim(); s.pc = 32'h88; s.store = 1'b1; s.addr = 32'h77; s.mtvec = 32'h201;
        run(s, 1'b0);
        // mret.
        s = base_stim(); s.mret = 1'b1; s.mstatus = 32'h1880; s.mepc_q = 32'h104;
        s.mcause_q = 32'h2; s.mtval_q = 32'hDEAD_BEEF; s.mtvec = 32'h300;
        run(s, 1'b1);
        // Timer pending but MIE=0: ignored; then ebreak.
        s = base_stim(); s.mtip = 1'b1; s.mtie = 1'b1; s.mstatus = 32'h0; s.pc = 32'h200;
        run(s, 1'b0);
        s.ebreak = 1'b1; s.pc = 32'h204;
        run(s, 1'b0);
        // Valid low: nothing happens even with a cause.
        s = base_stim(); s.valid = 1'b0; s.illegal = 1'b1;
        run(s, 1'b0);

        // Reset during COMMIT.
        s = base_stim(); s.illegal = 1'b1; s.pc = 32'h300; s.mstatus = 32'h8;
        apply(s);
        @(posedge clk);
        #1;
        chk("pre_rst_we", 32'(we_exc_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_we", 32'(we_exc_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_flush", 32'(flush_o), 32'd0);
        chk("mid_rst_mcause", mcause_d_o, 32'd0);
        @(negedge clk);
        clear_events();
        @(negedge clk);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_redirect", 32'(redirect_o), 32'd0);
            chk("post_rst_stall", 32'(stall_o), 32'd0);
        end

        for (int n = 0; n < 400; n++) begin
            run(rand_stim(), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
